// File: rtl/operand_forward_unit.sv
// operand_forward_unit: EX/MEM tag tracking, registered operand-forward selects and load-use stall detection
module operand_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall_id,
  output logic                  ex_load_pending,
  output logic [CNT_W-1:0]      stall_count
);
  logic                  ex_valid, ex_we, ex_load, mem_valid, mem_we;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic                  ex_a, ex_b, mem_a, mem_b, zero_a, zero_b, kill;
  logic [1:0]            next_a, next_b;
  always_comb begin
    zero_a = (ZERO_REG_EN != 0) && id_rs == '0;
    zero_b = (ZERO_REG_EN != 0) && id_rt == '0;
    ex_a = id_rs_used && !zero_a && ex_valid && ex_we && ex_rd == id_rs;
    ex_b = id_rt_used && !zero_b && ex_valid && ex_we && ex_rd == id_rt;
    mem_a = id_rs_used && !zero_a && mem_valid && mem_we && mem_rd == id_rs;
    mem_b = id_rt_used && !zero_b && mem_valid && mem_we && mem_rd == id_rt;
    stall_id = id_valid && !flush && (ex_a || ex_b) && ex_load;
    kill = flush || stall_id || !id_valid;
    next_a = kill ? 2'd0 : ex_a ? 2'd1 : mem_a ? 2'd2 : 2'd0;
    next_b = kill ? 2'd0 : ex_b ? 2'd1 : mem_b ? 2'd2 : 2'd0;
  end
  assign ex_load_pending = ex_valid && ex_load;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      fwd_sel_a   <= 2'd0;
      fwd_sel_b   <= 2'd0;
      stall_count <= '0;
    end else if (!pipe_hold) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      ex_valid  <= id_valid && !flush && !stall_id;
      ex_rd     <= id_rd;
      ex_we     <= id_valid && id_rd_we;
      ex_load   <= id_valid && id_is_load;
      fwd_sel_a <= next_a;
      fwd_sel_b <= next_b;
      if (stall_id && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed vectors pushed to a scoreboard queue, popped and compared by a monitor
module tb_operand_forward_unit;
  logic       clk = 1'b0;
  logic       reset, id_valid, id_rs_used, id_rt_used, id_rd_we, id_is_load, pipe_hold, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       stall_id, ex_load_pending;
  logic [3:0] stall_count;
  typedef struct {
    logic       chk;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
    logic       pd;
    logic [3:0] cn;
    int         id;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;
  logic [3:0] cnt;
  always #5 clk = ~clk;
  operand_forward_unit #(.REG_ADDR_W(5), .ZERO_REG_EN(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .pipe_hold(pipe_hold), .flush(flush), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall_id(stall_id), .ex_load_pending(ex_load_pending),
    .stall_count(stall_count)
  );
  task automatic cmp(input string name, input int id, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, id, act, want);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        cmp("stall_id", e.id, {7'd0, stall_id}, {7'd0, e.st});
        cmp("fwd_sel_a", e.id, {6'd0, fwd_sel_a}, {6'd0, e.a});
        cmp("fwd_sel_b", e.id, {6'd0, fwd_sel_b}, {6'd0, e.b});
        cmp("ex_load_pending", e.id, {7'd0, ex_load_pending}, {7'd0, e.pd});
        cmp("stall_count", e.id, {4'd0, stall_count}, {4'd0, e.cn});
      end
    end
  end
  task automatic step(input logic rs_t, input logic v, input logic [4:0] rs, input logic ru,
                      input logic [4:0] rt, input logic tu, input logic [4:0] rd, input logic we,
                      input logic ld, input logic hd, input logic fl, input logic c, input logic st,
                      input logic [1:0] a, input logic [1:0] b, input logic pd, input logic [3:0] cn);
    exp_t e;
    @(negedge clk);
    reset = rs_t; id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_rd = rd; id_rd_we = we; id_is_load = ld; pipe_hold = hd; flush = fl;
    e.chk = c; e.st = st; e.a = a; e.b = b; e.pd = pd; e.cn = cn; e.id = vec;
    q.push_back(e);
    vec++;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    // rst v  rs ru rt tu rd we ld hd fl | c st a b pd cnt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 7, 1, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 4, 1, 13, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 4, 1, 13, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 4, 1, 13, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 4, 1, 13, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 4, 1, 13, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2);
    step(0, 1, 0, 0, 0, 0, 14, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 14, 1, 0, 0, 15, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 0, 1, 0, 1, 15, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 0, 1, 0, 0, 16, 1, 0, 0, 0, 1, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    cnt = 4'd2;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0, 0, 0, cnt);
      step(0, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 1, 0, 0, 1, cnt);
      cnt = (cnt == 4'hf) ? 4'hf : cnt + 4'd1;
      step(0, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0, cnt);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, cnt);
    end
    step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0, 0, 0, 15);
    step(1, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 1, 0, 0, 1, 15);
    step(0, 1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
